mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the RV32IM execute stage, successor to the fixed 32-bit shift-add/restoring MDU. Executes all eight M-extension funct3 operations at configurable width and bits-per-cycle, and returns a single rd-ready result. Both sides use valid/ready handshakes with a passthrough tag. Supports early-out for trivial operands, pipeline flush, and response back-pressure.

---
 rtl/mdu_iter_pkg.sv | 22 ++
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_iter.sv | 163 ++++++++++++++++
 tb/tb_mdu_iter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// M-extension funct3 codes and the FSM state encoding.
package mdu_iter_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response handshake bundle between the execute stage and mdu_iter.
interface mdu_iter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_funct3, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        input  req_valid, req_funct3, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/mdu_div_step.sv
// Combinational restoring-division step: retires DIV_STEP quotient bits,
// consuming dividend bits MSB first.
module mdu_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_STEP = 1
) (
    input  logic [XLEN:0]       rem_in,
    input  logic [XLEN-1:0]     divisor,
    input  logic [DIV_STEP-1:0] dvd_bits,
    output logic [XLEN:0]       rem_out,
    output logic [DIV_STEP-1:0] q_bits
);
    logic [XLEN:0] r;

    // Partial remainder stays below the divisor, so the shifted-out MSB is always zero.
    always_comb begin
        r      = rem_in;
        q_bits = '0;
        for (int unsigned i = 0; i < DIV_STEP; i++) begin
            r = {r[XLEN-1:0], dvd_bits[DIV_STEP-1-i]};
            if (r >= {1'b0, divisor}) begin
                r                      = r - {1'b0, divisor};
                q_bits[DIV_STEP-1-i]   = 1'b1;
            end
        end
        rem_out = r;
    end
endmodule

// File: rtl/mdu_iter.sv
// Parametrised iterative RV32IM multiply/divide unit with early-out,
// flush and response back-pressure.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_STEP  = 2,
    parameter int DIV_STEP  = 1,
    parameter int TAG_W     = 5,
    parameter int EARLY_OUT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    output logic      busy,
    mdu_iter_if.slave bus
);
    localparam int unsigned MUL_ITERS = XLEN / MUL_STEP;
    localparam int unsigned DIV_ITERS = XLEN / DIV_STEP;
    localparam int unsigned CNT_W     = $clog2(XLEN);

    state_t                state;
    logic [2:0]            f3_q;
    logic [XLEN-1:0]       a_q, b_q, dq, result_q;
    logic [XLEN:0]         rem_q, rem_next;
    logic [2*XLEN-1:0]     acc, acc_next, prod_s;
    logic [TAG_W-1:0]      tag_q;
    logic [CNT_W-1:0]      cnt;
    logic                  neg_q, ovr_q;

    logic                  is_div, a_sign, b_sign, mul_zero, b_zero, div_ovf, div_special, early, res_neg;
    logic [XLEN-1:0]       a_mag, b_mag, special_val, fix_val;
    logic [XLEN+MUL_STEP-1:0]          mul_sum;
    logic [2*XLEN+MUL_STEP-1:0]        mul_wide;
    logic [DIV_STEP-1:0]               q_bits;
    logic [XLEN+DIV_STEP-1:0]          dq_wide;

    // Operand decode for the accept cycle: magnitudes, result sign, trivial cases.
    always_comb begin
        is_div      = bus.req_funct3[2];
        a_sign      = bus.req_a[XLEN-1] && (bus.req_funct3 == F3_MULH || bus.req_funct3 == F3_MULHSU ||
                                            bus.req_funct3 == F3_DIV  || bus.req_funct3 == F3_REM);
        b_sign      = bus.req_b[XLEN-1] && (bus.req_funct3 == F3_MULH || bus.req_funct3 == F3_DIV ||
                                            bus.req_funct3 == F3_REM);
        a_mag       = a_sign ? -bus.req_a : bus.req_a;
        b_mag       = b_sign ? -bus.req_b : bus.req_b;
        res_neg     = 1'b0;
        if (bus.req_funct3 == F3_MULH || bus.req_funct3 == F3_DIV)
            res_neg = a_sign ^ b_sign;
        else if (bus.req_funct3 == F3_MULHSU || bus.req_funct3 == F3_REM)
            res_neg = a_sign;
        mul_zero    = (bus.req_a == '0) || (bus.req_b == '0);
        b_zero      = (bus.req_b == '0);
        div_ovf     = (bus.req_funct3 == F3_DIV || bus.req_funct3 == F3_REM) &&
                      (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
        div_special = is_div && (b_zero || div_ovf);
        special_val = '0;
        if (is_div && b_zero)
            special_val = bus.req_funct3[1] ? bus.req_a : '1;
        else if (is_div && div_ovf)
            special_val = bus.req_funct3[1] ? '0 : bus.req_a;
        early       = (EARLY_OUT != 0) && (is_div ? div_special : mul_zero);
    end

    // Shift-add multiply: accumulator high half collects partial products,
    // low half holds the not-yet-consumed multiplier bits.
    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]};
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (acc[i])
                mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, a_q} << i);
        end
        mul_wide = {mul_sum, acc[XLEN-1:0]};
        acc_next = mul_wide[2*XLEN+MUL_STEP-1:MUL_STEP];
    end

    mdu_div_step #(
        .XLEN     (XLEN),
        .DIV_STEP (DIV_STEP)
    ) u_div_step (
        .rem_in   (rem_q),
        .divisor  (b_q),
        .dvd_bits (dq[XLEN-1 -: DIV_STEP]),
        .rem_out  (rem_next),
        .q_bits   (q_bits)
    );

    assign dq_wide = {dq, q_bits};

    always_comb begin
        prod_s = neg_q ? -acc : acc;
        if (f3_q[2])
            fix_val = f3_q[1] ? (neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0])
                              : (neg_q ? -dq : dq);
        else
            fix_val = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dq       <= '0;
            rem_q    <= '0;
            acc      <= '0;
            tag_q    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            ovr_q    <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    f3_q     <= bus.req_funct3;
                    tag_q    <= bus.req_tag;
                    neg_q    <= res_neg;
                    ovr_q    <= div_special;
                    a_q      <= a_mag;
                    b_q      <= b_mag;
                    acc      <= {{XLEN{1'b0}}, b_mag};
                    dq       <= a_mag;
                    rem_q    <= '0;
                    result_q <= special_val;
                    cnt      <= is_div ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MUL_ITERS - 1);
                    state    <= early ? ST_RESP : (is_div ? ST_DIV : ST_MUL);
                end
                ST_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= ST_FIX;
                end
                ST_DIV: begin
                    rem_q <= rem_next;
                    dq    <= dq_wide[XLEN-1:0];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    // Divide-by-zero / overflow value was preloaded at accept.
                    if (!ovr_q)
                        result_q <= fix_val;
                    state <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready)
                    state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE) && !flush;
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_result = result_q;
    assign bus.rsp_tag    = tag_q;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32, MUL_STEP=2, DIV_STEP=1) against
// an arithmetic reference model of the RV32M operations.
module tb_mdu_iter;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
    int   n_checks;
    int   n_fail;

    mdu_iter_if #(.XLEN(32), .TAG_W(5)) bus ();

    mdu_iter #(
        .XLEN      (32),
        .MUL_STEP  (2),
        .DIV_STEP  (1),
        .TAG_W     (5),
        .EARLY_OUT (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        if (f3 < 3'd4) trivial = (a == 0) || (b == 0);
        else trivial = (b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (trivial) return 1;
        return (f3 < 3'd4) ? 18 : 34;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one request, waits for the response (bounded), completes the handshake.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res, output logic [4:0] rtag,
                          output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 100) begin @(negedge clk); guard++; end
        bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res  = bus.rsp_result;
        rtag = bus.rsp_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got %h want 0", bus.rsp_result); end
        n_checks++; if (bus.rsp_tag !== 5'h0) begin n_fail++; $display("FAIL reset_rsp_tag got %h want 0", bus.rsp_tag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        flush = 1'b1; #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_flush got %b want 0", bus.req_ready); end
        flush = 1'b0; #1;
    endtask

    task automatic test_directed();
        logic [31:0] r; logic [4:0] t; int lat;
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 5'h01, r, t, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_result got %h want ffffffff", r); end
        n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL mulh_latency got %0d want 18", lat); end
        run_op(3'd2, 32'hFFFF_FFFF, 32'h2, 5'h02, r, t, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_result got %h want ffffffff", r); end
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, r, t, lat);
        n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_result got %h want fffffffe", r); end
        n_checks++; if (t !== 5'h1F) begin n_fail++; $display("FAIL mulhu_tag got %h want 1f", t); end
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, r, t, lat);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL mul_result got %h want 00000001", r); end
        n_checks++; if (t !== 5'h1F) begin n_fail++; $display("FAIL mul_tag got %h want 1f", t); end
        run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 5'h04, r, t, lat);
        n_checks++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_result got %h want fffffffd", r); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
        run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 5'h06, r, t, lat);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_result got %h want ffffffff", r); end
        n_checks++; if (t !== 5'h06) begin n_fail++; $display("FAIL rem_tag got %h want 06", t); end
    endtask

    task automatic test_early_out();
        logic [2:0]  f3s [5] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd0};
        logic [31:0] as  [5] = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'd0};
        logic [31:0] r; logic [4:0] t; int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(f3s[i], as[i], bs[i], 5'(i + 8), r, t, lat);
            n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL early_result[%0d] got %h want %h", i, r, exp[i]); end
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL early_latency[%0d] got %0d want 1", i, lat); end
            n_checks++; if (t !== 5'(i + 8)) begin n_fail++; $display("FAIL early_tag[%0d] got %h want %h", i, t, 5'(i + 8)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r; logic [2:0] f3; logic [4:0] tag, t; int lat;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7)); a = rand_operand(); b = rand_operand(); tag = 5'($urandom);
            run_op(f3, a, b, tag, r, t, lat);
            n_checks++; if (r !== ref_result(f3, a, b)) begin n_fail++;
                $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, r, ref_result(f3, a, b)); end
            n_checks++; if (lat !== ref_latency(f3, a, b)) begin n_fail++;
                $display("FAIL rand_latency[%0d] f3=%0d got %0d want %0d", i, f3, lat, ref_latency(f3, a, b)); end
            n_checks++; if (t !== tag) begin n_fail++; $display("FAIL rand_tag[%0d] got %h want %h", i, t, tag); end
        end
    endtask

    task automatic test_back_to_back();
        int guard; int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = 3'd3; bus.req_a = 32'hFFFF_FFFF; bus.req_b = 32'hFFFF_FFFF;
        bus.req_tag = 5'h15; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.rsp_valid && guard < 100) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.rsp_valid); end
            n_checks++; if (bus.rsp_result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL bp_result[%0d] got %h want fffffffe", i, bus.rsp_result); end
            n_checks++; if (bus.rsp_tag !== 5'h15) begin n_fail++; $display("FAIL bp_tag[%0d] got %h want 15", i, bus.rsp_tag); end
            n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, bus.req_ready); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'd5; bus.req_a = 32'd100; bus.req_b = 32'd7; bus.req_tag = 5'h03;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL b2b_handshake busy=%b rsp_valid=%b want 0/0", busy, bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy got %b want 1", busy); end
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++; if (bus.rsp_result !== 32'd14) begin n_fail++; $display("FAIL b2b_result got %h want 0000000e", bus.rsp_result); end
        n_checks++; if (bus.rsp_tag !== 5'h03) begin n_fail++; $display("FAIL b2b_tag got %h want 03", bus.rsp_tag); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [4:0] t; int lat; int seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = 3'd0; bus.req_a = 32'd3; bus.req_b = 32'd5; bus.req_tag = 5'h02;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'd5; bus.req_a = 32'd1; bus.req_b = 32'd1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_req_ready got %b want 0", bus.req_ready); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_abort busy=%b rsp_valid=%b want 0/0", busy, bus.rsp_valid); end
        // flush held while idle with a request pending: must not be accepted
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accept busy got %b want 0", busy); end
        flush = 1'b0; bus.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_rsp got %0d responses want 0", seen); end
        run_op(3'd5, 32'd100, 32'd7, 5'h07, r, t, lat);
        n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL post_flush_result got %h want 0000000e", r); end
        n_checks++; if (t !== 5'h07) begin n_fail++; $display("FAIL post_flush_tag got %h want 07", t); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = 3'd4; bus.req_a = 32'd1000; bus.req_b = 32'd3;
        bus.req_tag = 5'h1A; bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid busy=%b rsp_valid=%b want 0/0", busy, bus.rsp_valid); end
        n_checks++; if (bus.rsp_tag !== 5'h0 || bus.rsp_result !== 32'h0) begin n_fail++;
            $display("FAIL rst_mid_data tag=%h result=%h want 0/0", bus.rsp_tag, bus.rsp_result); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req_ready got %b want 1", bus.req_ready); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_after busy=%b rsp_valid=%b want 0/0", busy, bus.rsp_valid); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        test_reset();
        test_directed();
        test_early_out();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
